// File: rtl/bg_render_pkg.sv
`default_nettype none
// ============================================================================
// Module : bg_render_pkg
// Brief  : Shared types and constants for the scrolling background renderer.
// Rev    : 1.0  initial release
// ============================================================================
package bg_render_pkg;

  localparam int unsigned CAM_W     = 16;
  // address register plus colour register on top of the map-ROM latency
  localparam int unsigned LAT_FIXED = 2;

  typedef struct packed {
    logic [CAM_W-1:0] x;
    logic [CAM_W-1:0] y;
  } camera_t;

  function automatic int unsigned addr_w(input int unsigned map_w, input int unsigned map_h);
    return $clog2(map_w * map_h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_bg_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : scroll_bg_addr_gen
// Brief  : Camera capture, scaled x/y source counters and map-ROM address.
//          BG_WRAP_EN selects wrap-around at the map edge (default: clamp).
// Rev    : 1.0  initial release
// ============================================================================
module scroll_bg_addr_gen
  import bg_render_pkg::*;
#(
  parameter  int unsigned MAP_W    = 1968,
  parameter  int unsigned MAP_H    = 128,
  parameter  int unsigned SCALE_X  = 7,
  parameter  int unsigned SCALE_Y  = 9,
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned V_ACTIVE = 480,
  localparam int unsigned AW       = addr_w(MAP_W, MAP_H),
  localparam int unsigned CXW      = $clog2(MAP_W),
  localparam int unsigned CYW      = $clog2(MAP_H)
) (
  input  logic           vga_clk,
  input  logic           reset,
  input  logic [9:0]     DrawX,
  input  logic [9:0]     DrawY,
  input  logic [CXW-1:0] cam_x,
  input  logic [CYW-1:0] cam_y,
  input  logic           cam_load,
  output logic           cam_applied,
  output logic [AW-1:0]  rom_addr
);

  localparam int unsigned XSW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int unsigned YSW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  camera_t        cam_pend_q, cam_pend_d, cam_act_q, cam_act_d, load_cam;
  logic           pend_q, pend_d, applied_q, applied_d;
  logic [CXW-1:0] src_x_q, src_x_d, cur_x;
  logic [XSW-1:0] xsub_q, xsub_d, cur_xsub;
  logic [CYW-1:0] src_y_q, src_y_d;
  logic [YSW-1:0] ysub_q, ysub_d;
  logic [AW-1:0]  row_base_q, row_base_d, rom_addr_q, rom_addr_d;
  logic           line_start, frame_edge, line_end;
  logic           unused_cam_bits;

  assign unused_cam_bits = ^{cam_act_q.x[CAM_W-1:CXW], cam_act_d.y[CAM_W-1:CYW]};

  always_comb begin
    line_start = (DrawX == '0);
    frame_edge = line_start && (DrawY == 10'(V_ACTIVE));
    line_end   = (DrawX == 10'(H_ACTIVE - 1)) && (DrawY < 10'(V_ACTIVE));

    load_cam   = '0;
    load_cam.x = (cam_x > CXW'(MAP_W - 1)) ? CAM_W'(MAP_W - 1) : CAM_W'(cam_x);
    load_cam.y = (cam_y > CYW'(MAP_H - 1)) ? CAM_W'(MAP_H - 1) : CAM_W'(cam_y);

    cam_pend_d = cam_pend_q;
    pend_d     = pend_q;
    cam_act_d  = cam_act_q;
    applied_d  = 1'b0;
    if (cam_load) begin
      cam_pend_d = load_cam;
      pend_d     = 1'b1;
    end
    // a load landing on the boundary itself is applied immediately
    if (frame_edge && (pend_q || cam_load)) begin
      cam_act_d = cam_load ? load_cam : cam_pend_q;
      pend_d    = 1'b0;
      applied_d = 1'b1;
    end

    src_y_d    = src_y_q;
    ysub_d     = ysub_q;
    row_base_d = row_base_q;
    if (frame_edge) begin
      src_y_d    = cam_act_d.y[CYW-1:0];
      ysub_d     = '0;
      row_base_d = AW'(cam_act_d.y[CYW-1:0]) * AW'(MAP_W);
    end else if (line_end) begin
      if (ysub_q == YSW'(SCALE_Y - 1)) begin
        ysub_d = '0;
        if (src_y_q != CYW'(MAP_H - 1)) begin
          src_y_d    = src_y_q + 1'b1;
          row_base_d = row_base_q + AW'(MAP_W);
        end else begin
`ifdef BG_WRAP_EN
          src_y_d    = '0;
          row_base_d = '0;
`else
          src_y_d    = src_y_q;
          row_base_d = row_base_q;
`endif
        end
      end else begin
        ysub_d = ysub_q + 1'b1;
      end
    end

    // the line-start reload must already steer this pixel's address
    cur_x    = line_start ? cam_act_q.x[CXW-1:0] : src_x_q;
    cur_xsub = line_start ? '0 : xsub_q;
    src_x_d  = cur_x;
    xsub_d   = cur_xsub;
    if (DrawX < 10'(H_ACTIVE)) begin
      if (cur_xsub == XSW'(SCALE_X - 1)) begin
        xsub_d = '0;
        if (cur_x != CXW'(MAP_W - 1)) begin
          src_x_d = cur_x + 1'b1;
        end else begin
`ifdef BG_WRAP_EN
          src_x_d = '0;
`else
          src_x_d = cur_x;
`endif
        end
      end else begin
        xsub_d = cur_xsub + 1'b1;
      end
    end

    rom_addr_d = row_base_q + AW'(cur_x);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cam_pend_q <= '0;
      cam_act_q  <= '0;
      pend_q     <= 1'b0;
      applied_q  <= 1'b0;
      src_x_q    <= '0;
      xsub_q     <= '0;
      src_y_q    <= '0;
      ysub_q     <= '0;
      row_base_q <= '0;
      rom_addr_q <= '0;
    end else begin
      cam_pend_q <= cam_pend_d;
      cam_act_q  <= cam_act_d;
      pend_q     <= pend_d;
      applied_q  <= applied_d;
      src_x_q    <= src_x_d;
      xsub_q     <= xsub_d;
      src_y_q    <= src_y_d;
      ysub_q     <= ysub_d;
      row_base_q <= row_base_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign cam_applied = applied_q;
  assign rom_addr    = rom_addr_q;

endmodule
`default_nettype wire

// File: rtl/scroll_bg_renderer.sv
`default_nettype none
// ============================================================================
// Module : scroll_bg_renderer
// Brief  : Scrolling, scaled tile-map background; address generation plus
//          blank-aligned palette colour pipeline. Honours BG_WRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module scroll_bg_renderer
  import bg_render_pkg::*;
#(
  parameter  int unsigned MAP_W    = 1968,
  parameter  int unsigned MAP_H    = 128,
  parameter  int unsigned SCALE_X  = 7,
  parameter  int unsigned SCALE_Y  = 9,
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned V_ACTIVE = 480,
  parameter  int unsigned ROM_LAT  = 1,
  parameter  int unsigned PIX_W    = 4,
  parameter  int unsigned COLOR_W  = 4,
  localparam int unsigned AW       = addr_w(MAP_W, MAP_H),
  localparam int unsigned CXW      = $clog2(MAP_W),
  localparam int unsigned CYW      = $clog2(MAP_H)
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic [CXW-1:0]     cam_x,
  input  logic [CYW-1:0]     cam_y,
  input  logic               cam_load,
  output logic               cam_applied,
  output logic [AW-1:0]      rom_addr,
  input  logic [PIX_W-1:0]   rom_q,
  output logic [PIX_W-1:0]   pal_index,
  input  logic [COLOR_W-1:0] pal_red,
  input  logic [COLOR_W-1:0] pal_green,
  input  logic [COLOR_W-1:0] pal_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int unsigned LAT = ROM_LAT + LAT_FIXED;

  logic [LAT-2:0]     blank_sr_q, blank_sr_d;
  logic               started_q, started_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  scroll_bg_addr_gen #(
    .MAP_W    (MAP_W),
    .MAP_H    (MAP_H),
    .SCALE_X  (SCALE_X),
    .SCALE_Y  (SCALE_Y),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .cam_x       (cam_x),
    .cam_y       (cam_y),
    .cam_load    (cam_load),
    .cam_applied (cam_applied),
    .rom_addr    (rom_addr)
  );

  assign pal_index = rom_q;

  always_comb begin
    // after reset, pixels are not trusted until the counters see a line start
    started_d  = started_q | (DrawX == '0);
    blank_sr_d = {blank_sr_q[LAT-3:0], blank & started_d};
    red_d      = '0;
    green_d    = '0;
    blue_d     = '0;
    if (blank_sr_q[LAT-2]) begin
      red_d   = pal_red;
      green_d = pal_green;
      blue_d  = pal_blue;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_sr_q <= '0;
      started_q  <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      blank_sr_q <= blank_sr_d;
      started_q  <= started_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
`default_nettype wire
